// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit datapath: word width, bubble encoding
// and the fetch-stage state type.
package cpu_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_e;

  // PC arithmetic wraps silently at the word width.
  function automatic logic [WORD_W-1:0] pc_inc(input logic [WORD_W-1:0] pc);
    return pc + WORD_W'(1);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry buffer that parks an instruction word returned while the
// IF/ID register is stalled. Clear beats load, load beats drain.
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              drain,
  input  logic              clear,
  input  logic [WORD_W-1:0] instr_in,
  input  logic [WORD_W-1:0] pc_in,
  output logic [WORD_W-1:0] instr_out,
  output logic [WORD_W-1:0] pc_out,
  output logic              full
);

  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic              full_q, full_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    full_d  = full_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (load) begin
      instr_d = instr_in;
      pc_d    = pc_in;
      full_d  = 1'b1;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      full_q  <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      full_q  <= full_d;
    end
  end

  assign instr_out = instr_q;
  assign pc_out    = pc_q;
  assign full      = full_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: program counter, req/ready fetch from instruction
// memory, and the IF/ID register feeding the register file.
module instr_fetch #(
  parameter logic [cpu_pkg::WORD_W-1:0] RESET_PC  = 16'h0000,
  parameter logic [cpu_pkg::WORD_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       branch_taken,
  input  logic [cpu_pkg::WORD_W-1:0] branch_target,
  output logic                       imem_req,
  output logic [cpu_pkg::WORD_W-1:0] imem_addr,
  input  logic                       imem_ready,
  input  logic [cpu_pkg::WORD_W-1:0] imem_rdata,
  output logic [cpu_pkg::WORD_W-1:0] instruc_out,
  output logic [cpu_pkg::WORD_W-1:0] pc_out,
  output logic                       instr_valid
);

  import cpu_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] pc_out_q, pc_out_d;
  logic              valid_q, valid_d;

  logic              buf_load, buf_drain, buf_clear;
  logic [WORD_W-1:0] buf_instr, buf_pc;
  logic              buf_full;
  logic              transfer;

  // Request is a pure decode of registered state, never of imem_ready.
  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign transfer  = imem_req && imem_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc_out_d  = pc_out_q;
    valid_d   = valid_q;
    buf_load  = 1'b0;
    buf_drain = 1'b0;
    buf_clear = 1'b0;

    if (branch_taken) begin
      pc_d      = branch_target;
      buf_clear = 1'b1;
      instr_d   = NOP_INSTR;
      pc_out_d  = pc_q;
      valid_d   = 1'b0;
      state_d   = S_FETCH;
    end else begin
      case (state_q)
        S_RESET: state_d = S_FETCH;
        S_FETCH: begin
          if (stall) begin
            if (transfer) begin
              buf_load = 1'b1;
              pc_d     = pc_inc(pc_q);
              state_d  = S_HOLD;
            end
          end else if (transfer) begin
            instr_d  = imem_rdata;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_inc(pc_q);
          end else begin
            instr_d  = NOP_INSTR;
            pc_out_d = pc_q;
            valid_d  = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            instr_d   = buf_instr;
            pc_out_d  = buf_pc;
            valid_d   = buf_full;
            buf_drain = 1'b1;
            state_d   = S_FETCH;
          end
        end
        default: state_d = S_RESET;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RESET;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

  fetch_skid_buf u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (buf_load),
    .drain     (buf_drain),
    .clear     (buf_clear),
    .instr_in  (imem_rdata),
    .pc_in     (pc_q),
    .instr_out (buf_instr),
    .pc_out    (buf_pc),
    .full      (buf_full)
  );

  assign instruc_out = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table followed by
// randomized traffic compared against a behavioural model.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [15:0] instruc_out;
  logic [15:0] pc_out;
  logic        instr_valid;

  int n_checks;
  int n_fail;

  logic [15:0] mem [0:65535];

  typedef struct {
    logic        rst;
    logic        stl;
    logic        br;
    logic [15:0] tgt;
    logic        rdy;
    logic [15:0] e_instr;
    logic [15:0] e_pc;
    logic        e_valid;
    logic        e_req;
    logic [15:0] e_addr;
  } vec_t;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
  } entry_t;

  vec_t vecs[19];

  // Behavioural model: fetching flag, PC, a queue for parked words, IF/ID.
  bit          m_started;
  logic [15:0] m_pc;
  entry_t      m_buf[$];
  logic [15:0] m_instr;
  logic [15:0] m_pcout;
  logic        m_valid;

  instr_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instruc_out   (instruc_out),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers the presented address; garbage when not ready.
  always_comb imem_rdata = imem_ready ? mem[imem_addr] : 16'hBAD0;

  task automatic applyStimulus(input logic rst, input logic stl, input logic br,
                               input logic [15:0] tgt, input logic rdy);
    @(negedge clk);
    reset         = rst;
    stall         = stl;
    branch_taken  = br;
    branch_target = tgt;
    imem_ready    = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep(input logic rst, input logic stl, input logic br,
                           input logic [15:0] tgt, input logic rdy);
    logic [15:0] word;
    entry_t      e;
    word = mem[m_pc];
    if (rst) begin
      m_started = 0;
      m_pc      = 16'h0000;
      m_buf.delete();
      m_instr   = 16'h0000;
      m_pcout   = 16'h0000;
      m_valid   = 1'b0;
    end else if (br) begin
      m_instr   = 16'h0000;
      m_pcout   = m_pc;
      m_valid   = 1'b0;
      m_pc      = tgt;
      m_buf.delete();
      m_started = 1;
    end else if (!m_started) begin
      m_started = 1;
    end else if (m_buf.size() != 0) begin
      if (!stl) begin
        e       = m_buf.pop_front();
        m_instr = e.instr;
        m_pcout = e.pc;
        m_valid = 1'b1;
      end
    end else if (rdy && stl) begin
      e.instr = word;
      e.pc    = m_pc;
      m_buf.push_back(e);
      m_pc = m_pc + 16'd1;
    end else if (rdy) begin
      m_instr = word;
      m_pcout = m_pc;
      m_valid = 1'b1;
      m_pc    = m_pc + 16'd1;
    end else if (!stl) begin
      m_instr = 16'h0000;
      m_pcout = m_pc;
      m_valid = 1'b0;
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic stl, input logic br,
                              input logic [15:0] tgt, input logic rdy,
                              input logic [15:0] ei, input logic [15:0] ep,
                              input logic ev, input logic er, input logic [15:0] ea);
    vec_t v;
    v.rst = rst; v.stl = stl; v.br = br; v.tgt = tgt; v.rdy = rdy;
    v.e_instr = ei; v.e_pc = ep; v.e_valid = ev; v.e_req = er; v.e_addr = ea;
    return v;
  endfunction

  initial begin
    logic r, s, b, y;
    logic [15:0] t;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    branch_target = 16'h0000; imem_ready = 1'b0;

    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0]       = 16'hF120;
    mem[1]       = 16'h1234;
    mem[2]       = 16'hABCD;
    mem[3]       = 16'h3333;
    mem[16'h40]  = 16'h4040;
    mem[16'hFFFF] = 16'hEEEE;

    //             rst stl br tgt       rdy instr     pc_out    v  req addr
    vecs[0]  = mk(1, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000);
    vecs[1]  = mk(0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0, 1, 16'h0000);
    vecs[2]  = mk(0, 0, 0, 16'h0000, 1, 16'hF120, 16'h0000, 1, 1, 16'h0001);
    vecs[3]  = mk(0, 0, 0, 16'h0000, 1, 16'h1234, 16'h0001, 1, 1, 16'h0002);
    vecs[4]  = mk(0, 1, 0, 16'h0000, 1, 16'h1234, 16'h0001, 1, 0, 16'h0003);
    vecs[5]  = mk(0, 1, 0, 16'h0000, 1, 16'h1234, 16'h0001, 1, 0, 16'h0003);
    vecs[6]  = mk(0, 1, 0, 16'h0000, 0, 16'h1234, 16'h0001, 1, 0, 16'h0003);
    vecs[7]  = mk(0, 0, 0, 16'h0000, 1, 16'hABCD, 16'h0002, 1, 1, 16'h0003);
    vecs[8]  = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0003, 0, 1, 16'h0003);
    vecs[9]  = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0003, 0, 1, 16'h0003);
    vecs[10] = mk(0, 0, 0, 16'h0000, 1, 16'h3333, 16'h0003, 1, 1, 16'h0004);
    vecs[11] = mk(0, 1, 1, 16'h0040, 1, 16'h0000, 16'h0004, 0, 1, 16'h0040);
    vecs[12] = mk(0, 0, 0, 16'h0000, 1, 16'h4040, 16'h0040, 1, 1, 16'h0041);
    vecs[13] = mk(0, 0, 1, 16'hFFFF, 1, 16'h0000, 16'h0041, 0, 1, 16'hFFFF);
    vecs[14] = mk(0, 0, 0, 16'h0000, 1, 16'hEEEE, 16'hFFFF, 1, 1, 16'h0000);
    vecs[15] = mk(0, 1, 0, 16'h0000, 1, 16'hEEEE, 16'hFFFF, 1, 0, 16'h0001);
    vecs[16] = mk(1, 1, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000);
    vecs[17] = mk(0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0, 1, 16'h0000);
    vecs[18] = mk(0, 0, 0, 16'h0000, 1, 16'hF120, 16'h0000, 1, 1, 16'h0001);

    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].stl, vecs[i].br, vecs[i].tgt, vecs[i].rdy);
      checkOutput($sformatf("vec%0d instruc_out", i), instruc_out, vecs[i].e_instr);
      checkOutput($sformatf("vec%0d pc_out", i), pc_out, vecs[i].e_pc);
      checkOutput($sformatf("vec%0d instr_valid", i), 16'(instr_valid), 16'(vecs[i].e_valid));
      checkOutput($sformatf("vec%0d imem_req", i), 16'(imem_req), 16'(vecs[i].e_req));
      checkOutput($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].e_addr);
    end

    // Hand sequence: a long stall in S_HOLD must not lose or duplicate the word.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
    checkOutput("long hold req", 16'(imem_req), 16'h0000);
    checkOutput("long hold instr", instruc_out, 16'hF120);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("release instr", instruc_out, mem[1]);
    checkOutput("release pc", pc_out, 16'h0001);
    checkOutput("release req", 16'(imem_req), 16'h0001);
    checkOutput("release addr", imem_addr, 16'h0002);

    // Randomized phase against the behavioural model.
    modelStep(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 59) == 0);
      b = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 2) == 0);
      y = ($urandom_range(0, 2) != 0);
      t = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      modelStep(r, s, b, t, y);
      applyStimulus(r, s, b, t, y);
      checkOutput("rand instruc_out", instruc_out, m_instr);
      checkOutput("rand pc_out", pc_out, m_pcout);
      checkOutput("rand instr_valid", 16'(instr_valid), 16'(m_valid));
      checkOutput("rand imem_req", 16'(imem_req),
                  16'(m_started && (m_buf.size() == 0)));
      checkOutput("rand imem_addr", imem_addr, m_pc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
